mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the single shared memory bus between instruction fetch and LDR/STR data accesses.
//  Arbitrates requests, drives sel_add_bus of the address-bus mux (0 = PC address, 1 = register-bank
//  address), issues read/write strobes, waits on mem_ready, returns data. Stalls the PC while a
//  fetch is pending. Aborts with bus_error when memory does not answer within TIMEOUT cycles.
// PARAMETERS
//  DATA_W   32  memory data width
//  TIMEOUT  15  max cycles in an access state without mem_ready before abort (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  fetch_req    in   1       level; instruction fetch wanted; held until fetch_done
//  fetch_done   out  1       1-cycle pulse; instr_out valid
//  instr_out    out  DATA_W  fetched instruction, registered, holds until next fetch
//  pc_stall     out  1       1 in FETCH/LOAD/STORE; PC must not advance
//  ldr          in   1       level; load wanted; held until ldr_done
//  ldr_done     out  1       1-cycle pulse; ldr_data valid
//  ldr_data     out  DATA_W  loaded word, registered, holds until next load
//  str          in   1       level; store wanted; held until str_done
//  str_data     in   DATA_W  store data, sampled on STORE entry
//  str_done     out  1       1-cycle pulse; store complete
//  sel_add_bus  out  1       address-mux select, registered
//  mem_rd       out  1       read strobe, held for whole access
//  mem_wr       out  1       write strobe, held for whole access
//  mem_wdata    out  DATA_W  write data, registered, stable while mem_wr=1
//  mem_rdata    in   DATA_W  read data, valid when mem_ready=1
//  mem_ready    in   1       memory completes current access this cycle
//  bus_error    out  1       1-cycle pulse with the done pulse of an aborted access
// BEHAVIOUR
//  - States: IDLE, FETCH, LOAD, STORE, DONE. Requests sampled only in IDLE.
//  - Priority in IDLE: ldr > str > fetch_req. A losing request stays pending.
//  - ldr and str together: protocol violation; LOAD first, then STORE once str still high in IDLE.
//  - IDLE->LOAD/STORE: sel_add_bus<=1; mem_rd or mem_wr <=1; STORE: mem_wdata<=str_data.
//  - IDLE->FETCH: sel_add_bus<=0, mem_rd<=1.
//  - Access state, mem_ready=1: capture mem_rdata (FETCH->instr_out, LOAD->ldr_data); strobes<=0;
//    go DONE. mem_ready outside an access state is ignored.
//  - DONE: matching done pulse high one cycle; then IDLE. Requester drops request on that edge.
//  - Latency: request seen at edge N -> strobe high cycle N+1 -> zero-wait done high cycle N+2.
//    N wait states add N cycles. Back-to-back accesses are 3 cycles apart (IDLE, access, DONE).
//  - Timeout: counter clears on access entry, increments each access cycle without mem_ready.
//    On reaching TIMEOUT: strobes<=0, DONE with done+bus_error; data register unchanged.
//  - sel_add_bus holds its last value in IDLE/DONE; reset value 0 (PC path).
//  - Address sources (pc_addr, register-bank address) are held stable by requesters during access.
//  - rst (async): state IDLE, every output 0, instr_out/ldr_data/mem_wdata 0, counter 0, including
//    mid-access (strobes drop immediately, no done pulse).
// STRUCTURE
//  - Shared package mem_ctrl_pkg: state encodings (IDLE..DONE), DATA_W default, TIMEOUT default.
//  - One sub-module: mem_timeout_counter (clear, enable, TIMEOUT param, expired flag).
//  - All outputs registered; no combinational path from mem_ready to strobes.
// TESTING
//  1 Zero-wait fetch: fetch_req=1, mem_ready=1, mem_rdata=32'hE3A01005 -> mem_rd=1,sel_add_bus=0
//    at N+1; fetch_done=1, instr_out=32'hE3A01005 at N+2; pc_stall=1 only at N+1.
//  2 Load, 3 wait states: ldr=1, mem_ready high 4th access cycle, mem_rdata=32'h12345678 ->
//    sel_add_bus=1, mem_rd high 4 cycles, ldr_done one cycle, ldr_data=32'h12345678.
//  3 Priority: fetch_req=1 and str=1, str_data=32'hDEADBEEF same edge -> STORE first (mem_wr=1,
//    mem_wdata=32'hDEADBEEF), str_done, then FETCH with sel_add_bus=0.
//  4 ldr=1 and str=1 together -> LOAD completes, ldr_done, then STORE, str_done; never both strobes.
//  5 Timeout: TIMEOUT=15, mem_ready=0 forever on a load -> mem_rd drops after 15 access cycles;
//    ldr_done and bus_error pulse together; ldr_data keeps prior value.
//  6 Reset mid-access: rst=1 while STORE waiting -> mem_wr=0 immediately, all outputs 0, no
//    str_done; after release with str=1 store restarts from IDLE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding,
// default parameter values and a small state-classification helper.
package mem_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 15;

    // FETCH/LOAD/STORE are the access states in which a strobe is held on the bus.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True while a bus access is outstanding.
    function automatic logic is_access(input state_t s);
        return (s == ST_FETCH) || (s == ST_LOAD) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts access cycles spent without mem_ready. The expired flag is high in
// the cycle that would make the count reach TIMEOUT, so the controller can
// abort on the same edge the TIMEOUT-th waiting cycle ends.
module mem_timeout_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable; otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Shared memory bus sequencer. Arbitrates load, store and instruction fetch
// requests (ldr > str > fetch), drives the address-mux select and read/write
// strobes, waits for mem_ready and returns the read word. Every output is a
// flop, so mem_ready never reaches a strobe combinationally.
//
// Handshake: each requester raises its level request and holds it until its
// done pulse; the request is dropped on the edge that ends the done cycle.
// Requests are only looked at in IDLE, so a losing request simply waits.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    output logic              fetch_done,
    output logic [DATA_W-1:0] instr_out,
    output logic              pc_stall,
    input  logic              ldr,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_data,
    input  logic              str,
    input  logic [DATA_W-1:0] str_data,
    output logic              str_done,
    output logic              sel_add_bus,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_error,
    output state_t            dbg_state
);

    state_t            state_q,       state_d;
    logic              sel_add_bus_q, sel_add_bus_d;
    logic              mem_rd_q,      mem_rd_d;
    logic              mem_wr_q,      mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [DATA_W-1:0] instr_q,       instr_d;
    logic [DATA_W-1:0] ldr_data_q,    ldr_data_d;
    logic              fetch_done_q,  fetch_done_d;
    logic              ldr_done_q,    ldr_done_d;
    logic              str_done_q,    str_done_d;
    logic              bus_error_q,   bus_error_d;
    logic              pc_stall_q,    pc_stall_d;

    logic in_access;
    logic tmo_expired;

    assign in_access = is_access(state_q);

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_access),
        .enable  (in_access && !mem_ready),
        .expired (tmo_expired)
    );

    // Next-state and registered-output logic; done/error pulses default low.
    always_comb begin
        state_d       = state_q;
        sel_add_bus_d = sel_add_bus_q;
        mem_rd_d      = mem_rd_q;
        mem_wr_d      = mem_wr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_d       = instr_q;
        ldr_data_d    = ldr_data_q;
        pc_stall_d    = pc_stall_q;
        fetch_done_d  = 1'b0;
        ldr_done_d    = 1'b0;
        str_done_d    = 1'b0;
        bus_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ldr) begin
                    state_d       = ST_LOAD;
                    sel_add_bus_d = 1'b1;
                    mem_rd_d      = 1'b1;
                    pc_stall_d    = 1'b1;
                end else if (str) begin
                    state_d       = ST_STORE;
                    sel_add_bus_d = 1'b1;
                    mem_wr_d      = 1'b1;
                    mem_wdata_d   = str_data;
                    pc_stall_d    = 1'b1;
                end else if (fetch_req) begin
                    state_d       = ST_FETCH;
                    sel_add_bus_d = 1'b0;
                    mem_rd_d      = 1'b1;
                    pc_stall_d    = 1'b1;
                end
            end

            ST_FETCH, ST_LOAD, ST_STORE: begin
                if (mem_ready || tmo_expired) begin
                    state_d      = ST_DONE;
                    mem_rd_d     = 1'b0;
                    mem_wr_d     = 1'b0;
                    pc_stall_d   = 1'b0;
                    bus_error_d  = !mem_ready;
                    fetch_done_d = (state_q == ST_FETCH);
                    ldr_done_d   = (state_q == ST_LOAD);
                    str_done_d   = (state_q == ST_STORE);
                    if (mem_ready && state_q == ST_FETCH) begin
                        instr_d = mem_rdata;
                    end
                    if (mem_ready && state_q == ST_LOAD) begin
                        ldr_data_d = mem_rdata;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_add_bus_q <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_wdata_q   <= '0;
            instr_q       <= '0;
            ldr_data_q    <= '0;
            pc_stall_q    <= 1'b0;
            fetch_done_q  <= 1'b0;
            ldr_done_q    <= 1'b0;
            str_done_q    <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_add_bus_q <= sel_add_bus_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_q       <= instr_d;
            ldr_data_q    <= ldr_data_d;
            pc_stall_q    <= pc_stall_d;
            fetch_done_q  <= fetch_done_d;
            ldr_done_q    <= ldr_done_d;
            str_done_q    <= str_done_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign sel_add_bus = sel_add_bus_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wdata   = mem_wdata_q;
    assign instr_out   = instr_q;
    assign ldr_data    = ldr_data_q;
    assign pc_stall    = pc_stall_q;
    assign fetch_done  = fetch_done_q;
    assign ldr_done    = ldr_done_q;
    assign str_done    = str_done_q;
    assign bus_error   = bus_error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. The bench plays both the requesters and the
// memory. Its model works per transaction: service order from the priority
// rule, strobe length = min(waits+1, TIMEOUT), then one done cycle, then one
// idle cycle; read words pass through an expected queue.
module tb_mem_access_ctrl;

  localparam int TO      = 15;
  localparam int K_FETCH = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic        fetch_done;
  logic [31:0] instr_out;
  logic        pc_stall;
  logic        ldr;
  logic        ldr_done;
  logic [31:0] ldr_data;
  logic        str;
  logic [31:0] str_data;
  logic        str_done;
  logic        sel_add_bus;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_error;
  logic [2:0]  dbg_state;

  // Reference state
  logic [31:0] exp_instr;
  logic [31:0] exp_ldr;
  logic [31:0] exp_wdata;
  logic        exp_sel;
  logic [31:0] exp_q[$];

  int n_vec;
  int n_err;

  mem_access_ctrl #(
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_done  (fetch_done),
    .instr_out   (instr_out),
    .pc_stall    (pc_stall),
    .ldr         (ldr),
    .ldr_done    (ldr_done),
    .ldr_data    (ldr_data),
    .str         (str),
    .str_data    (str_data),
    .str_done    (str_done),
    .sel_add_bus (sel_add_bus),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .bus_error   (bus_error),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the expectation for the current cycle.
  task automatic expect_cycle(input string ph, input logic rd, input logic wr, input logic stall,
                              input logic fd, input logic ld, input logic sd, input logic be);
    check({ph, ".mem_rd"},      mem_rd,      rd);
    check({ph, ".mem_wr"},      mem_wr,      wr);
    check({ph, ".both_strb"},   mem_rd & mem_wr, 1'b0);
    check({ph, ".pc_stall"},    pc_stall,    stall);
    check({ph, ".fetch_done"},  fetch_done,  fd);
    check({ph, ".ldr_done"},    ldr_done,    ld);
    check({ph, ".str_done"},    str_done,    sd);
    check({ph, ".bus_error"},   bus_error,   be);
    check({ph, ".sel_add_bus"}, sel_add_bus, exp_sel);
    check({ph, ".instr_out"},   instr_out,   exp_instr);
    check({ph, ".ldr_data"},    ldr_data,    exp_ldr);
    check({ph, ".mem_wdata"},   mem_wdata,   exp_wdata);
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(TO - 2, TO + 5));
    return int'($urandom_range(0, 3));
  endfunction

  // One access: called at the falling edge of an IDLE cycle with the request
  // already up; returns at the falling edge of the IDLE cycle that follows DONE.
  task automatic do_service(input int kind, input int w, input logic [31:0] rdata);
    int   c;
    logic fin;
    logic rdy;
    logic tmo;
    logic [31:0] e;
    @(posedge clk); @(negedge clk);
    exp_sel = (kind != K_FETCH);
    if (kind == K_STORE) exp_wdata = str_data;
    c   = 1;
    fin = 1'b0;
    while (!fin) begin
      expect_cycle("acc", kind != K_STORE, kind == K_STORE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rdy       = (c == w + 1);
      mem_ready = rdy;
      mem_rdata = rdy ? rdata : $urandom();
      if (rdy && kind != K_STORE) exp_q.push_back(rdata);
      fin = rdy || (c == TO);
      c++;
      @(posedge clk); @(negedge clk);
    end
    tmo = (w + 1 > TO);
    if (!tmo && kind == K_FETCH) exp_instr = rdata;
    if (!tmo && kind == K_LOAD)  exp_ldr   = rdata;
    // mem_ready outside an access must be ignored
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom();
    expect_cycle("done", 1'b0, 1'b0, 1'b0, kind == K_FETCH, kind == K_LOAD, kind == K_STORE, tmo);
    if (!tmo && kind != K_STORE && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_data", (kind == K_FETCH) ? instr_out : ldr_data, e);
    end
    case (kind)
      K_FETCH: fetch_req = 1'b0;
      K_LOAD:  ldr       = 1'b0;
      default: str       = 1'b0;
    endcase
    @(posedge clk); @(negedge clk);
    expect_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom();
  endtask

  // Raise a set of requests together; service order is ldr, str, fetch.
  task automatic run_txn(input logic f, input logic l, input logic s,
                         input int wf, input int wl, input int ws,
                         input logic [31:0] df, input logic [31:0] dl, input logic [31:0] sdata);
    if (s) str_data = sdata;
    fetch_req = f;
    ldr       = l;
    str       = s;
    if (l) do_service(K_LOAD,  wl, dl);
    if (s) do_service(K_STORE, ws, 32'h0);
    if (f) do_service(K_FETCH, wf, df);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
      str_data  = $urandom();
      @(posedge clk); @(negedge clk);
      expect_cycle("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_model();
    exp_instr = '0;
    exp_ldr   = '0;
    exp_wdata = '0;
    exp_sel   = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [2:0] pat;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    fetch_req = 1'b0;
    ldr       = 1'b0;
    str       = 1'b0;
    str_data  = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.state", dbg_state, 3'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Zero-wait fetch
    run_txn(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'hE3A01005, 32'h0, 32'h0);
    // Load with three wait states
    run_txn(1'b0, 1'b1, 1'b0, 0, 3, 0, 32'h0, 32'h12345678, 32'h0);
    // Store beats fetch, fetch follows
    run_txn(1'b1, 1'b0, 1'b1, 0, 0, 0, 32'hE1A00000, 32'h0, 32'hDEADBEEF);
    // ldr and str together: load then store
    run_txn(1'b0, 1'b1, 1'b1, 0, 1, 2, 32'h0, 32'hA5A5A5A5, 32'h0BADF00D);
    // Ready on the last allowed cycle, then one cycle too late
    run_txn(1'b0, 1'b1, 1'b0, 0, TO - 1, 0, 32'h0, 32'h55AA55AA, 32'h0);
    run_txn(1'b0, 1'b1, 1'b0, 0, TO, 0, 32'h0, 32'hFFFFFFFF, 32'h0);
    // Memory never answers a load or a fetch
    run_txn(1'b0, 1'b1, 1'b0, 0, 1000, 0, 32'h0, 32'h11111111, 32'h0);
    run_txn(1'b1, 1'b0, 1'b0, 1000, 0, 0, 32'h22222222, 32'h0, 32'h0);
    idle_cycles(3);

    // Reset while a store is waiting
    str_data = 32'hCAFEF00D;
    str      = 1'b1;
    @(posedge clk); @(negedge clk);
    exp_sel   = 1'b1;
    exp_wdata = 32'hCAFEF00D;
    mem_ready = 1'b0;
    expect_cycle("rst_acc", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    expect_cycle("rst_acc2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    reset_model();
    expect_cycle("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    expect_cycle("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    do_service(K_STORE, 1, 32'h0);
    idle_cycles(2);

    // Randomized request mixes
    for (int t = 0; t < 150; t++) begin
      pat = 3'($urandom_range(1, 7));
      run_txn(pat[0], pat[1], pat[2], rand_wait(), rand_wait(), rand_wait(),
              $urandom(), $urandom(), $urandom());
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
